// File: rtl/din_rvs_conditioner.sv
// Input conditioner: synchronizes a bouncy asynchronous din, debounces it and
// drives a registered inverted level plus a time-limited enable window.
module din_rvs_conditioner #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CNT      = 16,
  parameter int unsigned EN_HOLD     = 4,
  parameter int unsigned CNT_W       = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic din_rvs,
  output logic en,
  output logic chg_pulse
);

  typedef enum logic [1:0] {IDLE, CHECK, HOLD} state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CNT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(EN_HOLD - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   db_lvl;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;

  assign s = sync_q[SYNC_STAGES-1];
  // din_rvs is the only stored copy of the debounced level.
  assign db_lvl = ~din_rvs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      din_rvs   <= 1'b1;
      en        <= 1'b0;
      chg_pulse <= 1'b0;
    end else begin
      chg_pulse <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          en  <= 1'b0;
          if (s != db_lvl) begin
            state <= CHECK;
            cnt   <= CNT_W'(1);
          end
        end
        CHECK: begin
          // A single matching sample discards the candidate outright.
          if (s == db_lvl) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            din_rvs   <= ~s;
            chg_pulse <= 1'b1;
            en        <= 1'b1;
            cnt       <= HOLD_LAST;
            state     <= HOLD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            en    <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          en    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_din_rvs_conditioner.sv
// Directed bench for din_rvs_conditioner: expected outputs are queued per clock
// edge when stimulus is applied and checked as that edge comes around.
module tb_din_rvs_conditioner;

  logic clk;
  logic rst_n;
  logic din, din2;
  logic rvs_a, en_a, p_a;
  logic rvs_b, en_b, p_b;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  typedef struct {
    int    cyc;
    bit    dut;
    logic  rvs;
    logic  en;
    logic  pulse;
    string tag;
  } exp_t;

  exp_t sb[$];

  din_rvs_conditioner dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_rvs   (rvs_a),
    .en        (en_a),
    .chg_pulse (p_a)
  );

  din_rvs_conditioner #(
    .SYNC_STAGES (3),
    .DB_CNT      (2),
    .EN_HOLD     (1),
    .CNT_W       (5)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din2),
    .din_rvs   (rvs_b),
    .en        (en_b),
    .chg_pulse (p_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Scoreboard checker: compare every entry due at the edge just taken.
  always @(negedge clk) begin
    exp_t e;
    logic [2:0] obs;
    logic [2:0] want;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        e    = sb[i];
        obs  = e.dut ? {rvs_b, en_b, p_b} : {rvs_a, en_a, p_a};
        want = {e.rvs, e.en, e.pulse};
        compared++;
        assert (obs === want && e.cyc == cyc) else begin
          mismatched++;
          $error("FAIL %s dut=%0d edge=%0d (now %0d) rvs/en/pulse got %b expected %b",
                 e.tag, e.dut, e.cyc, cyc, obs, want);
        end
        sb.delete(i);
      end
    end
  end

  task automatic push(input bit dut, input int t, input logic r, input logic e,
                      input logic p, input string tag);
    exp_t x;
    x.cyc = t; x.dut = dut; x.rvs = r; x.en = e; x.pulse = p; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic push_range(input bit dut, input int t0, input int t1, input logic r,
                            input logic e, input logic p, input string tag);
    for (int t = t0; t <= t1; t++) push(dut, t, r, e, p, tag);
  endtask

  // Default instance: din first sampled at edge e0, new level new_lvl accepted at e0+17.
  task automatic expect_accept_a(input int e0, input logic new_lvl, input string tag);
    push(1'b0, e0 + 16, new_lvl,  1'b0, 1'b0, {tag, "_pre"});
    push(1'b0, e0 + 17, ~new_lvl, 1'b1, 1'b1, {tag, "_acc"});
    push(1'b0, e0 + 18, ~new_lvl, 1'b1, 1'b0, {tag, "_en1"});
    push(1'b0, e0 + 20, ~new_lvl, 1'b1, 1'b0, {tag, "_en3"});
    push(1'b0, e0 + 21, ~new_lvl, 1'b0, 1'b0, {tag, "_enoff"});
  endtask

  task automatic check_now(input bit dut, input logic r, input logic e, input logic p,
                           input string tag);
    logic [2:0] obs;
    obs = dut ? {rvs_b, en_b, p_b} : {rvs_a, en_a, p_a};
    compared++;
    assert (obs === {r, e, p}) else begin
      mismatched++;
      $error("FAIL %s dut=%0d rvs/en/pulse got %b expected %b", tag, dut, obs, {r, e, p});
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int e0;
    int acc;
    rst_n = 1'b0;
    din   = 1'b1;
    din2  = 1'b0;
    repeat (3) @(negedge clk);
    check_now(1'b0, 1'b1, 1'b0, 1'b0, "reset_a");
    check_now(1'b1, 1'b1, 1'b0, 1'b0, "reset_b");

    // Release with din already high: full sync + debounce latency from first sample.
    rst_n = 1'b1;
    e0 = cyc + 1;
    push(1'b0, e0, 1'b1, 1'b0, 1'b0, "rst_release");
    expect_accept_a(e0, 1'b1, "rst_rise");
    wait_until(e0 + 22);

    din = 1'b0;
    e0 = cyc + 1;
    expect_accept_a(e0, 1'b0, "fall");
    wait_until(e0 + 22);

    din = 1'b1;
    e0 = cyc + 1;
    expect_accept_a(e0, 1'b1, "rise");
    wait_until(e0 + 22);

    // Sub-clock glitch between edges must never reach the synchronizer output.
    #2 din = 1'b0;
    #2 din = 1'b1;
    push_range(1'b0, cyc + 1, cyc + 20, 1'b0, 1'b0, 1'b0, "subclk_glitch");
    wait_until(cyc + 21);

    // Sweep instance: accept at E+4, single-clock en with the pulse.
    din2 = 1'b1;
    e0 = cyc + 1;
    push(1'b1, e0,     1'b1, 1'b0, 1'b0, "b_rise_e0");
    push(1'b1, e0 + 3, 1'b1, 1'b0, 1'b0, "b_rise_pre");
    push(1'b1, e0 + 4, 1'b0, 1'b1, 1'b1, "b_rise_acc");
    push(1'b1, e0 + 5, 1'b0, 1'b0, 1'b0, "b_rise_enoff");
    wait_until(e0 + 7);
    din2 = 1'b0;
    e0 = cyc + 1;
    push(1'b1, e0 + 3, 1'b0, 1'b0, 1'b0, "b_fall_pre");
    push(1'b1, e0 + 4, 1'b1, 1'b1, 1'b1, "b_fall_acc");
    push(1'b1, e0 + 5, 1'b1, 1'b0, 1'b0, "b_fall_enoff");
    wait_until(e0 + 7);
    din2 = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    din2 = 1'b0;
    push_range(1'b1, e0, e0 + 8, 1'b1, 1'b0, 1'b0, "b_one_clk_glitch");
    wait_until(e0 + 9);

    din = 1'b0;
    e0 = cyc + 1;
    expect_accept_a(e0, 1'b0, "fall2");
    wait_until(e0 + 22);

    // Bounce 1,0,1,0 every 5 clocks, then settle high.
    push_range(1'b0, cyc + 1, cyc + 20, 1'b1, 1'b0, 1'b0, "bounce");
    for (int seg = 0; seg < 4; seg++) begin
      din = (seg % 2 == 0) ? 1'b1 : 1'b0;
      repeat (5) @(negedge clk);
    end
    din = 1'b1;
    e0 = cyc + 1;
    push_range(1'b0, e0, e0 + 15, 1'b1, 1'b0, 1'b0, "settle_wait");
    expect_accept_a(e0, 1'b1, "settle");
    acc = e0 + 17;

    // din falls two clocks after acceptance; HOLD ignores it, CHECK restarts after IDLE re-entry.
    wait_until(acc + 1);
    din = 1'b0;
    push(1'b0, acc + 3,  1'b0, 1'b1, 1'b0, "hold_chg_en_last");
    push(1'b0, acc + 4,  1'b0, 1'b0, 1'b0, "hold_chg_idle");
    push(1'b0, acc + 19, 1'b0, 1'b0, 1'b0, "hold_chg_pre");
    push(1'b0, acc + 20, 1'b1, 1'b1, 1'b1, "hold_chg_acc");
    push(1'b0, acc + 21, 1'b1, 1'b1, 1'b0, "hold_chg_en1");
    push(1'b0, acc + 24, 1'b1, 1'b0, 1'b0, "hold_chg_enoff");
    wait_until(acc + 25);

    // Reset at cnt=10 in CHECK, then a full count is needed again.
    din = 1'b1;
    e0 = cyc + 1;
    push(1'b0, e0 + 11, 1'b1, 1'b0, 1'b0, "pre_rst_check");
    wait_until(e0 + 11);
    #2 rst_n = 1'b0;
    #1 check_now(1'b0, 1'b1, 1'b0, 1'b0, "rst_mid_check");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e0 = cyc + 1;
    push(1'b0, e0 + 16, 1'b1, 1'b0, 1'b0, "recount_pre");
    push(1'b0, e0 + 17, 1'b0, 1'b1, 1'b1, "recount_acc");
    wait_until(e0 + 18);

    // Reset inside HOLD drops en at once.
    #2 check_now(1'b0, 1'b0, 1'b1, 1'b0, "hold_before_rst");
    rst_n = 1'b0;
    #1 check_now(1'b0, 1'b1, 1'b0, 1'b0, "rst_mid_hold");
    check_now(1'b1, 1'b1, 1'b0, 1'b0, "rst_mid_hold_b");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e0 = cyc + 1;
    expect_accept_a(e0, 1'b1, "post_hold_rst");
    wait_until(e0 + 22);

    for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge clk);
    while (sb.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s never checked (due edge %0d, now %0d)", sb[0].tag, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
